// File: rtl/morse_tx.sv
// morse_tx: keys one Morse symbol (up to four dot/dash elements) onto a
// single line. A dot is 1 unit, a dash is 3 units, the gap between elements
// is 1 unit, and the closing gap after the last element is 3 units.
// One unit is UNIT_CYCLES clock cycles.
module morse_tx #(
  parameter int unsigned UNIT_CYCLES = 4
) (
  input  logic       CLKin,
  input  logic       RSTn,
  input  logic       start,
  input  logic [3:0] code,
  input  logic [2:0] len,
  input  logic       abort,
  output logic       key,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MARK = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_LGAP = 2'd3;

  // The counter must reach 3*UNIT_CYCLES-1, the longest interval (dash or closing gap).
  localparam int unsigned CW = $clog2(3 * UNIT_CYCLES);
  localparam logic [CW-1:0] UNIT_M1 = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] LONG_M1 = CW'(3 * UNIT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    code_q, code_d;
  logic [2:0]    len_q, len_d;
  logic          key_q, key_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [CW-1:0] mark_end;
  logic          last_elem;

  assign mark_end  = code_q[idx_q] ? LONG_M1 : UNIT_M1;
  assign last_elem = ({1'b0, idx_q} == (len_q - 3'd1));

  // Next-state logic. Outputs are derived from the next state so they are
  // registered together with it: key and busy change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    code_d  = code_q;
    len_d   = len_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start && !abort && (len != 3'd0)) begin
          state_d = S_MARK;
          code_d  = code;
          len_d   = (len > 3'd4) ? 3'd4 : len;
          idx_d   = '0;
        end
      end
      S_MARK: begin
        if (cnt_q == mark_end) begin
          cnt_d   = '0;
          state_d = last_elem ? S_LGAP : S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == UNIT_M1) begin
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          state_d = S_MARK;
        end
      end
      default: begin
        if (cnt_q == LONG_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      code_d  = '0;
      len_d   = '0;
      done_d  = 1'b0;
    end

    key_d  = (state_d == S_MARK);
    busy_d = (state_d != S_IDLE);
  end

  // State, counters, latched symbol and registered outputs.
  always_ff @(posedge CLKin or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      len_q   <= '0;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      len_q   <= len_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign key  = key_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_morse_tx.sv
// tb_morse_tx: cycle-by-cycle comparison of morse_tx against a waveform
// model that expands each accepted symbol into a queue of per-cycle
// {key,busy,done} values, plus hand-computed timing checks.
module tb_morse_tx;

  localparam int U = 4;

  logic       CLKin = 1'b0;
  logic       RSTn  = 1'b0;
  logic       start = 1'b0;
  logic [3:0] code  = '0;
  logic [2:0] len   = '0;
  logic       abort = 1'b0;
  logic       key, busy, done;

  morse_tx #(.UNIT_CYCLES(U)) dut (
    .CLKin (CLKin),
    .RSTn  (RSTn),
    .start (start),
    .code  (code),
    .len   (len),
    .abort (abort),
    .key   (key),
    .busy  (busy),
    .done  (done)
  );

  always #5 CLKin = ~CLKin;

  int compared   = 0;
  int mismatched = 0;

  // Model: queue of future cycles, each {key,busy,done}; mout is the current cycle.
  logic [2:0] sched[$];
  logic [2:0] mout = '0;
  logic       s_key, s_busy, s_done;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build(input logic [3:0] c, input logic [2:0] l);
    int n;
    int d;
    n = (l > 3'd4) ? 4 : int'(l);
    for (int e = 0; e < n; e++) begin
      d = c[e] ? 3 * U : U;
      for (int i = 0; i < d; i++) sched.push_back(3'b110);
      if (e < n - 1)
        for (int i = 0; i < U; i++) sched.push_back(3'b010);
    end
    for (int i = 0; i < 3 * U; i++) sched.push_back(3'b010);
    sched.push_back(3'b001);
  endtask

  task automatic model_step();
    if (!RSTn || abort) begin
      sched.delete();
      mout = '0;
    end else begin
      if (sched.size() == 0 && start && len != 3'd0) build(code, len);
      if (sched.size() > 0) mout = sched.pop_front();
      else mout = '0;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising
  // edge, then return 1 time unit later so the caller can change inputs.
  task automatic tick();
    @(negedge CLKin);
    s_key  = key;
    s_busy = busy;
    s_done = done;
    check("cyc_key",  int'(key),  int'(mout[2]));
    check("cyc_busy", int'(busy), int'(mout[1]));
    check("cyc_done", int'(done), int'(mout[0]));
    @(posedge CLKin);
    model_step();
    #1;
  endtask

  task automatic launch(input logic [3:0] c, input logic [2:0] l);
    code  = c;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int bcnt, dcnt, dcyc;

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_key",  int'(s_key),  0);
    check("rst_busy", int'(s_busy), 0);
    check("rst_done", int'(s_done), 0);
    RSTn = 1'b1;
    tick();

    // Dot-dash-dot exact waveform
    launch(4'b0010, 3'd3);
    for (int k = 1; k <= 41; k++) begin
      tick();
      check("ddd_key",  int'(s_key),
            int'((k <= 4) || (k >= 9 && k <= 20) || (k >= 25 && k <= 28)));
      check("ddd_busy", int'(s_busy), int'(k <= 40));
      check("ddd_done", int'(s_done), int'(k == 41));
    end

    // Single dash: 24 busy cycles, done right after
    launch(4'b0001, 3'd1);
    bcnt = 0; dcyc = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      bcnt += int'(s_busy);
      if (s_done) dcyc = k;
    end
    check("dash_busy_cycles", bcnt, 24);
    check("dash_done_cycle", dcyc, 25);

    // len=0 is ignored
    launch(4'b1111, 3'd0);
    bcnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      bcnt += int'(s_busy) + int'(s_done);
    end
    check("len0_busy", bcnt, 0);

    // len=7 clamps to 4 dashes; a start pulse mid-symbol is ignored
    launch(4'b1111, 3'd7);
    bcnt = 0; dcyc = 0;
    for (int k = 1; k <= 80; k++) begin
      start = (k == 30);
      code  = 4'b0000;
      len   = 3'd1;
      tick();
      bcnt += int'(s_busy);
      if (s_done) dcyc = k;
    end
    start = 1'b0;
    check("len7_busy_cycles", bcnt, 72);
    check("len7_done_cycle", dcyc, 73);

    // start held high: next symbol begins the cycle after done
    code  = 4'b0000;
    len   = 3'd1;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 17) begin
        check("b2b_done", int'(s_done), 1);
        check("b2b_busy_at_done", int'(s_busy), 0);
      end
      if (k == 18) begin
        check("b2b_key", int'(s_key), 1);
        check("b2b_busy", int'(s_busy), 1);
      end
    end
    start = 1'b0;
    for (int k = 0; k < 20; k++) tick();

    // Abort during the second element
    launch(4'b0000, 3'd3);
    for (int k = 1; k <= 9; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("abort_key", int'(s_key), 0);
    check("abort_busy", int'(s_busy), 0);
    dcnt = 0;
    for (int k = 0; k < 45; k++) begin
      tick();
      dcnt += int'(s_done);
    end
    check("abort_no_done", dcnt, 0);
    launch(4'b0010, 3'd3);
    dcnt = 0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      dcnt += int'(s_done);
    end
    check("post_abort_done", dcnt, 1);

    // Reset mid-mark truncates immediately
    launch(4'b0001, 3'd1);
    for (int k = 0; k < 5; k++) tick();
    RSTn = 1'b0;
    sched.delete();
    mout = '0;
    #1;
    check("rstmid_key", int'(key), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_done", int'(done), 0);
    tick();
    tick();
    RSTn = 1'b1;
    tick();
    launch(4'b0001, 3'd1);
    bcnt = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      bcnt += int'(s_busy);
    end
    check("post_rst_busy_cycles", bcnt, 24);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      start = ($urandom_range(0, 7) == 0);
      code  = 4'($urandom);
      len   = 3'($urandom_range(0, 7));
      abort = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 999) == 0) begin
        RSTn = 1'b0;
        sched.delete();
        mout = '0;
        tick();
        RSTn = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 80; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/morse_tx.md
MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 The block SHALL have parameter UNIT_CYCLES, default 4: clock cycles per Morse time unit, legal range 1..65535.
REQ-002 The block SHALL have port CLKin, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RSTn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to transmit one symbol.
REQ-005 The block SHALL have port code, input, 4 bits: element pattern; bit i = 1 means dash and 0 means dot; code[0] is sent first.
REQ-006 The block SHALL have port len, input, 3 bits: number of elements to send; 1..4 legal.
REQ-007 The block SHALL have port abort, input, 1 bit: cancel any transmission in progress.
REQ-008 The block SHALL have port key, output, 1 bit: Morse line; 1 = mark (tone on), 0 = space.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a symbol is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse on normal completion of a symbol.

Function
REQ-011 The block SHALL implement states IDLE, MARK, GAP and LGAP, with registered outputs key, busy and done.
REQ-012 In IDLE, start=1 with 1<=len<=4 SHALL latch code, latch len (values >4 clamped to 4) and set element index 0, then enter MARK on the next edge.
REQ-013 In IDLE, start=1 with len=0 SHALL be ignored: the block stays in IDLE and produces no busy or done.
REQ-014 start SHALL be ignored outside IDLE, and latched code/len SHALL NOT change mid-symbol.
REQ-015 MARK SHALL hold key=1 for exactly 1 unit (dot) or 3 units (dash) per the current element bit, where unit = UNIT_CYCLES cycles.
REQ-016 After MARK, if elements remain, the block SHALL go to GAP and hold key=0 for 1 unit, then increment the index and return to MARK.
REQ-017 After the last MARK, the block SHALL go to LGAP and hold key=0 for 3 units, then return to IDLE.
REQ-018 busy SHALL be 1 in MARK, GAP and LGAP, and 0 in IDLE.
REQ-019 done SHALL be 1 for exactly the first cycle back in IDLE after LGAP completes; busy SHALL be 0 in that cycle.
REQ-020 Latency: if start is sampled at edge T, key SHALL first be 1 in cycle T+1, and busy SHALL be 1 from T+1.
REQ-021 A start accepted in the done cycle SHALL begin a new symbol, so back-to-back symbols have no extra idle cycle.
REQ-022 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with key=0, busy=0, done=0, and latched data discarded.
REQ-023 abort and start both 1 in IDLE: abort SHALL win and no symbol starts.
REQ-024 The cycle counter SHALL be wide enough for 3*UNIT_CYCLES-1 without wrap, and SHALL be cleared on every state entry.

Reset
REQ-025 RSTn=0 SHALL immediately force IDLE with key=0, busy=0, done=0, counters=0 and latched code/len=0, regardless of CLKin.
REQ-026 Reset asserted mid-symbol SHALL truncate the mark immediately with no done pulse; after release the block SHALL accept start normally.

Verification
REQ-027 Dot-dash-dot: UNIT_CYCLES=4, code=4'b0010, len=3, start at T -> key=1 in T+1..T+4, 0 in T+5..T+8, 1 in T+9..T+20, 0 in T+21..T+24, 1 in T+25..T+28, 0 in T+29..T+40; done=1 only at T+41; busy=1 in T+1..T+40.
REQ-028 Single dash: code=4'b0001, len=1 -> one 12-cycle mark, then a 12-cycle space, then a done pulse; total busy time 24 cycles.
REQ-029 len=0 and len=7: len=0 -> busy stays 0; len=7 with code=4'b1111 -> four dashes, busy for 4*12+3*4+12=72 cycles.
REQ-030 start pulsed mid-symbol -> no effect on key timing; start held high through the done cycle -> the next symbol's first mark begins at done+1.
REQ-031 abort during the second element, and separately RSTn=0 mid-MARK -> key=0 at the next edge (abort) or immediately (reset), no done pulse, and a subsequent start transmits correctly.
